// File: rtl/dram_burst_ctrl.sv
// Line-wide read/write controller in front of the PIM DRAM model: sequences the
// burst beats, assembles read lines and returns one response per request.
`timescale 1ns/1ps
module dram_burst_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned BEAT_WIDTH     = 32,
    parameter int unsigned BURST_LEN      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [ADDR_WIDTH-1:0]           req_addr,
    input  logic [BURST_LEN*BEAT_WIDTH-1:0] req_wdata,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic                            resp_write,
    output logic [BURST_LEN*BEAT_WIDTH-1:0] resp_rdata,
    output logic                            resp_err,
    output logic [ADDR_WIDTH-1:0]           dram_addr,
    output logic                            dram_read_en,
    output logic                            dram_write_en,
    output logic [BEAT_WIDTH-1:0]           dram_wdata,
    input  logic                            dram_ready,
    input  logic                            dram_complete,
    input  logic [BEAT_WIDTH-1:0]           dram_rdata,
    input  logic                            dram_valid
);

    localparam int unsigned LINE_WIDTH = BURST_LEN * BEAT_WIDTH;
    localparam int unsigned CNT_W      = $clog2(BURST_LEN + 1);
    localparam int unsigned TO_W       = 32;

    localparam logic [CNT_W-1:0] BEATS_FULL = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(BURST_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT   = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_ACTIVE,
        S_RESP
    } state_t;

    state_t                  r_state,       w_state_nxt;
    logic                    r_req_ready,   w_req_ready_nxt;
    logic                    r_resp_valid,  w_resp_valid_nxt;
    logic                    r_resp_write,  w_resp_write_nxt;
    logic                    r_resp_err,    w_resp_err_nxt;
    logic [LINE_WIDTH-1:0]   r_resp_rdata,  w_resp_rdata_nxt;
    logic [ADDR_WIDTH-1:0]   r_dram_addr,   w_dram_addr_nxt;
    logic                    r_rd_en,       w_rd_en_nxt;
    logic                    r_wr_en,       w_wr_en_nxt;
    logic [CNT_W-1:0]        r_beat_cnt,    w_beat_cnt_nxt;
    logic [TO_W-1:0]         r_to_cnt,      w_to_cnt_nxt;
    logic                    r_lat_write,   w_lat_write_nxt;
    logic [ADDR_WIDTH-1:0]   r_lat_addr,    w_lat_addr_nxt;
    logic [LINE_WIDTH-1:0]   r_lat_wdata,   w_lat_wdata_nxt;

    logic [TO_W-1:0]         w_to_inc;
    logic                    w_timeout;
    logic                    w_beat_take;
    logic [CNT_W-1:0]        w_beat_cnt_upd;
    logic [CNT_W-1:0]        w_wbeat_sel;
    logic [BEAT_WIDTH-1:0]   w_wdata_beat;

    // Beats past a full line are ignored so the counter saturates instead of wrapping.
    assign w_to_inc       = r_to_cnt + TO_W'(1);
    assign w_timeout      = (w_to_inc >= TO_LIMIT);
    assign w_beat_take    = dram_valid && (r_beat_cnt < BEATS_FULL);
    assign w_beat_cnt_upd = w_beat_take ? (r_beat_cnt + CNT_W'(1)) : r_beat_cnt;
    assign w_wbeat_sel    = (r_beat_cnt >= BEATS_FULL) ? BEAT_LAST : r_beat_cnt;

    // Write beat mux: the only combinational output.
    always_comb begin
        w_wdata_beat = '0;
        for (int unsigned i = 0; i < BURST_LEN; i++) begin
            if (w_wbeat_sel == CNT_W'(i)) begin
                w_wdata_beat = r_lat_wdata[i*BEAT_WIDTH +: BEAT_WIDTH];
            end
        end
    end

    assign dram_wdata = w_wdata_beat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_write <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_dram_addr  <= '0;
            r_rd_en      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_beat_cnt   <= '0;
            r_to_cnt     <= '0;
            r_lat_write  <= 1'b0;
            r_lat_addr   <= '0;
            r_lat_wdata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_write <= w_resp_write_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_dram_addr  <= w_dram_addr_nxt;
            r_rd_en      <= w_rd_en_nxt;
            r_wr_en      <= w_wr_en_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_to_cnt     <= w_to_cnt_nxt;
            r_lat_write  <= w_lat_write_nxt;
            r_lat_addr   <= w_lat_addr_nxt;
            r_lat_wdata  <= w_lat_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_req_ready_nxt  = r_req_ready;
        w_resp_valid_nxt = r_resp_valid;
        w_resp_write_nxt = r_resp_write;
        w_resp_err_nxt   = r_resp_err;
        w_resp_rdata_nxt = r_resp_rdata;
        w_dram_addr_nxt  = r_dram_addr;
        w_rd_en_nxt      = r_rd_en;
        w_wr_en_nxt      = r_wr_en;
        w_beat_cnt_nxt   = r_beat_cnt;
        w_to_cnt_nxt     = r_to_cnt;
        w_lat_write_nxt  = r_lat_write;
        w_lat_addr_nxt   = r_lat_addr;
        w_lat_wdata_nxt  = r_lat_wdata;

        case (r_state)
            S_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_lat_write_nxt  = req_write;
                    w_lat_addr_nxt   = req_addr;
                    w_lat_wdata_nxt  = req_wdata;
                    w_resp_rdata_nxt = '0;
                    w_beat_cnt_nxt   = '0;
                    w_to_cnt_nxt     = '0;
                    w_req_ready_nxt  = 1'b0;
                    w_state_nxt      = S_WAIT_RDY;
                end
            end

            // Timeout wins over a late dram_ready so no enable is raised on an aborted request.
            S_WAIT_RDY: begin
                w_to_cnt_nxt = w_to_inc;
                if (w_timeout) begin
                    w_resp_err_nxt   = 1'b1;
                    w_resp_write_nxt = r_lat_write;
                    w_resp_valid_nxt = 1'b1;
                    w_state_nxt      = S_RESP;
                end else if (dram_ready) begin
                    w_rd_en_nxt     = !r_lat_write;
                    w_wr_en_nxt     = r_lat_write;
                    w_dram_addr_nxt = r_lat_addr;
                    w_state_nxt     = S_ACTIVE;
                end
            end

            S_ACTIVE: begin
                w_to_cnt_nxt   = w_to_inc;
                w_beat_cnt_nxt = w_beat_cnt_upd;
                for (int unsigned i = 0; i < BURST_LEN; i++) begin
                    if (w_beat_take && !r_lat_write && (r_beat_cnt == CNT_W'(i))) begin
                        w_resp_rdata_nxt[i*BEAT_WIDTH +: BEAT_WIDTH] = dram_rdata;
                    end
                end
                // A beat arriving with dram_complete is counted before the short-burst test.
                if (dram_complete) begin
                    w_rd_en_nxt      = 1'b0;
                    w_wr_en_nxt      = 1'b0;
                    w_resp_err_nxt   = (w_beat_cnt_upd != BEATS_FULL);
                    w_resp_write_nxt = r_lat_write;
                    w_resp_valid_nxt = 1'b1;
                    w_state_nxt      = S_RESP;
                end else if (w_timeout) begin
                    w_rd_en_nxt      = 1'b0;
                    w_wr_en_nxt      = 1'b0;
                    w_resp_err_nxt   = 1'b1;
                    w_resp_write_nxt = r_lat_write;
                    w_resp_valid_nxt = 1'b1;
                    w_state_nxt      = S_RESP;
                end
            end

            S_RESP: begin
                if (resp_ready) begin
                    w_resp_valid_nxt = 1'b0;
                    w_resp_err_nxt   = 1'b0;
                    w_req_ready_nxt  = 1'b1;
                    w_state_nxt      = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_write    = r_resp_write;
    assign resp_err      = r_resp_err;
    assign resp_rdata    = r_resp_rdata;
    assign dram_addr     = r_dram_addr;
    assign dram_read_en  = r_rd_en;
    assign dram_write_en = r_wr_en;

endmodule

// File: tb/tb_dram_burst_ctrl.sv
// Self-checking bench for dram_burst_ctrl: vector table, randomized transactions
// against a line-level model, and hand sequences for timeout, backpressure and reset.
`timescale 1ns/1ps
module tb_dram_burst_ctrl;

    localparam int unsigned AW = 16;
    localparam int unsigned BW = 32;
    localparam int unsigned BL = 8;
    localparam int unsigned LW = BL * BW;
    localparam int TO      = 1024;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_write;
    logic [LW-1:0] resp_rdata;
    logic          resp_err;
    logic [AW-1:0] dram_addr;
    logic          dram_read_en;
    logic          dram_write_en;
    logic [BW-1:0] dram_wdata;
    logic          dram_ready;
    logic          dram_complete;
    logic [BW-1:0] dram_rdata;
    logic          dram_valid;

    dram_burst_ctrl #(
        .ADDR_WIDTH    (AW),
        .BEAT_WIDTH    (BW),
        .BURST_LEN     (BL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_write   (resp_write),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .dram_addr    (dram_addr),
        .dram_read_en (dram_read_en),
        .dram_write_en(dram_write_en),
        .dram_wdata   (dram_wdata),
        .dram_ready   (dram_ready),
        .dram_complete(dram_complete),
        .dram_rdata   (dram_rdata),
        .dram_valid   (dram_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [31:0] beats [12];

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] base;
        logic [31:0] step;
        int          n;
        int          rdy;
        bit          merged;
        bit          exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%b required=%b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkv(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        chk1("en_exclusive", dram_read_en & dram_write_en, 1'b0);
    endtask

    // Line-level model: a response is clean only when a full line of beats arrived.
    function automatic bit model_err(input int n);
        return (n < BL);
    endfunction

    function automatic logic [LW-1:0] model_line(input int n, input bit want_mask);
        logic [LW-1:0] r;
        int m;
        r = '0;
        m = (n < BL) ? n : BL;
        for (int i = 0; i < m; i++) r[i*BW +: BW] = want_mask ? '1 : beats[i];
        return r;
    endfunction

    function automatic logic [LW-1:0] beats_line();
        logic [LW-1:0] r;
        for (int i = 0; i < BL; i++) r[i*BW +: BW] = beats[i];
        return r;
    endfunction

    task automatic do_accept(input bit wr, input logic [15:0] addr);
        chk1("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = beats_line();
        tick();
        req_valid = 1'b0;
        chk1("req_ready_busy", req_ready, 1'b0);
        cyc = 0;
    endtask

    task automatic do_dram(input bit wr, input logic [15:0] addr, input int n, input int rdy,
                           input bit merged, input int gap_max);
        dram_ready = 1'b0;
        for (int k = 0; k < rdy; k++) begin
            chk1("en_wait", dram_read_en | dram_write_en, 1'b0);
            tick();
        end
        chk1("en_wait", dram_read_en | dram_write_en, 1'b0);
        dram_ready = 1'b1;
        tick();
        dram_ready = 1'b0;
        chk1("read_en", dram_read_en, !wr);
        chk1("write_en", dram_write_en, wr);
        chkv("dram_addr", LW'(dram_addr), LW'(addr));
        for (int k = 0; k < n; k++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) tick();
            dram_valid = 1'b1;
            dram_rdata = beats[k];
            if (wr) chkv("dram_wdata", LW'(dram_wdata), LW'(beats[(k < BL) ? k : BL-1]));
            if (merged && k == n-1) dram_complete = 1'b1;
            tick();
            dram_valid = 1'b0;
            dram_rdata = '0;
            if (!(merged && k == n-1)) begin
                chk1("read_en_hold", dram_read_en, !wr);
                chk1("write_en_hold", dram_write_en, wr);
            end
        end
        if (!(merged && n > 0)) begin
            dram_complete = 1'b1;
            tick();
        end
        dram_complete = 1'b0;
    endtask

    task automatic do_resp(input bit wr, input int n, input bit exp_err, input int hold,
                           input int exp_lat);
        logic [LW-1:0] exp_line, mask;
        exp_line = model_line(n, 1'b0);
        mask     = model_line(n, 1'b1);
        if (exp_lat >= 0) chkv("latency", LW'(cyc), LW'(exp_lat));
        chk1("resp_valid", resp_valid, 1'b1);
        chk1("en_off_resp", dram_read_en | dram_write_en, 1'b0);
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) tick();
            chk1("resp_valid_hold", resp_valid, 1'b1);
            chk1("resp_err", resp_err, exp_err);
            chk1("resp_write", resp_write, wr);
            chk1("req_ready_resp", req_ready, 1'b0);
            if (!wr) chkv("resp_rdata", resp_rdata & mask, exp_line);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk1("resp_valid_drop", resp_valid, 1'b0);
        chk1("resp_err_clear", resp_err, 1'b0);
        chk1("req_ready_back", req_ready, 1'b1);
    endtask

    task automatic run_txn(input bit wr, input logic [15:0] addr, input int n, input int rdy,
                           input bit merged, input int gap_max, input bit exp_err,
                           input int hold, input int exp_lat);
        do_accept(wr, addr);
        do_dram(wr, addr, n, rdy, merged, gap_max);
        do_resp(wr, n, exp_err, hold, exp_lat);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0;
        dram_ready = 1'b0; dram_complete = 1'b0; dram_rdata = '0; dram_valid = 1'b0;

        vecs[0] = '{1'b0, 16'h0012, 32'h11111111, 32'h11111111, 8,  0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h0003, 32'h000000A0, 32'h00000001, 8,  0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 16'h0040, 32'hDEAD0000, 32'h00000101, 5,  1, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 16'h0041, 32'hC0DE0000, 32'h00000003, 10, 2, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 16'hFFFF, 32'h01234567, 32'h00000011, 8,  3, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 16'h1234, 32'h000000B0, 32'h00000001, 7,  0, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 16'h8000, 32'hF0000000, 32'h00001000, 9,  1, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 16'h0000, 32'h00000005, 32'h00000001, 0,  0, 1'b0, 1'b1};

        // Reset values
        repeat (3) @(negedge clk);
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_resp_err", resp_err, 1'b0);
        chk1("rst_resp_write", resp_write, 1'b0);
        chkv("rst_resp_rdata", resp_rdata, '0);
        chk1("rst_read_en", dram_read_en, 1'b0);
        chk1("rst_write_en", dram_write_en, 1'b0);
        chkv("rst_dram_addr", LW'(dram_addr), '0);
        chkv("rst_dram_wdata", LW'(dram_wdata), '0);
        rst = 1'b1;
        tick();

        // Vector table
        foreach (vecs[v]) begin
            for (int i = 0; i < 12; i++) beats[i] = vecs[v].base + 32'(i) * vecs[v].step;
            run_txn(vecs[v].wr, vecs[v].addr, vecs[v].n, vecs[v].rdy, vecs[v].merged, 0,
                    vecs[v].exp_err, 2,
                    vecs[v].rdy + 1 + vecs[v].n + ((vecs[v].merged && vecs[v].n > 0) ? 0 : 1));
        end

        // Randomized transactions against the model
        for (int t = 0; t < 40; t++) begin
            bit wr, merged;
            int n;
            for (int i = 0; i < 12; i++) beats[i] = $urandom;
            wr     = 1'($urandom_range(1, 0));
            merged = 1'($urandom_range(1, 0));
            n      = int'($urandom_range(11, 0));
            run_txn(wr, 16'($urandom), n, int'($urandom_range(4, 0)), merged, 2,
                    model_err(n), int'($urandom_range(3, 0)), -1);
        end

        // Timeout while waiting for dram_ready
        do_accept(1'b0, 16'h0ABC);
        dram_ready = 1'b0;
        while (!resp_valid && cyc < 2000) begin
            chk1("en_timeout", dram_read_en | dram_write_en, 1'b0);
            tick();
        end
        chkv("timeout_cycle", LW'(cyc), LW'(TO));
        do_resp(1'b0, 0, 1'b1, 3, -1);

        // Complete on the exact timeout edge takes priority
        for (int i = 0; i < 12; i++) beats[i] = 32'h5A5A0000 + 32'(i);
        do_accept(1'b0, 16'h0BCD);
        repeat (1000) tick();
        dram_ready = 1'b1;
        tick();
        dram_ready = 1'b0;
        for (int k = 0; k < BL; k++) begin
            dram_valid = 1'b1;
            dram_rdata = beats[k];
            tick();
        end
        dram_valid = 1'b0;
        while (cyc < TO - 1) tick();
        dram_complete = 1'b1;
        tick();
        dram_complete = 1'b0;
        do_resp(1'b0, 8, 1'b0, 0, TO);

        // Response backpressure with a second request waiting
        for (int i = 0; i < 12; i++) beats[i] = 32'h77000000 + 32'(i) * 32'h10;
        do_accept(1'b0, 16'h0100);
        do_dram(1'b0, 16'h0100, 8, 0, 1'b0, 0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0200;
        req_wdata = beats_line();
        do_resp(1'b0, 8, 1'b0, 20, -1);
        tick();
        req_valid = 1'b0;
        chk1("second_accept", req_ready, 1'b0);
        cyc = 0;
        do_dram(1'b1, 16'h0200, 8, 0, 1'b0, 0);
        do_resp(1'b1, 8, 1'b0, 0, -1);

        // Reset in the middle of a read burst
        for (int i = 0; i < 12; i++) beats[i] = 32'h3C000000 + 32'(i);
        do_accept(1'b0, 16'h0777);
        dram_ready = 1'b1;
        tick();
        dram_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dram_valid = 1'b1;
            dram_rdata = beats[k];
            tick();
        end
        dram_valid = 1'b0;
        chk1("pre_rst_read_en", dram_read_en, 1'b1);
        rst = 1'b0;
        #1;
        chk1("midrst_read_en", dram_read_en, 1'b0);
        chk1("midrst_write_en", dram_write_en, 1'b0);
        chk1("midrst_resp_valid", resp_valid, 1'b0);
        chk1("midrst_req_ready", req_ready, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk1("post_rst_resp_valid", resp_valid, 1'b0);
        for (int i = 0; i < 12; i++) beats[i] = 32'h9E000000 + 32'(i) * 32'h3;
        run_txn(1'b0, 16'h0778, 8, 1, 1'b0, 0, 1'b0, 1, 1 + 1 + 8 + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
